// File: rtl/barrett_precompute.sv
// barrett_precompute: derives k = ceil(log2 m) and mu = floor(2^(2k)/m) for barrett_pipelined.
// Optional last-modulus result cache is enabled by defining BARRETT_PRECOMP_CACHE_EN.
module barrett_precompute #(
  parameter int WIDTH = 64
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [WIDTH-1:0] m_i,
  output logic             busy_o,
  output logic             valid_o,
  output logic             error_o,
  output logic [WIDTH-1:0] m_o,
  output logic [WIDTH-1:0] m_bl_o,
  output logic [WIDTH-1:0] mu_o
);
  localparam int KW = $clog2(WIDTH);
  localparam int CW = KW + 1;

  typedef enum logic [1:0] {IDLE, LEN, DIV, DONE} state_t;
  state_t state_q, state_d;

  logic [WIDTH-1:0] m_q, q_q, q_next, r_q, r_next, hit_mu;
  logic [WIDTH:0]   r_shift;
  logic [KW-1:0]    k_q, len_k, hit_k;
  logic [CW-1:0]    cnt_q;
  logic             accept, len_err, div_last, r_ge, cache_hit;

  // k is the bit length of m-1, which is ceil(log2 m) and gives k=0 for m=1
  function automatic logic [KW-1:0] ceil_log2(input logic [WIDTH-1:0] m);
    logic [WIDTH-1:0] v;
    ceil_log2 = '0;
    v = m - WIDTH'(1);
    for (int i = 0; i < WIDTH; i++)
      if (v[i]) ceil_log2 = KW'(i + 1);
  endfunction

  assign accept   = start_i && ((state_q == IDLE) || (state_q == DONE));
  assign len_k    = ceil_log2(m_q);
  assign len_err  = (m_q == '0) || (m_q[WIDTH-1] && (|m_q[WIDTH-2:0]));
  assign div_last = (cnt_q == '0);

  // Remainder stays below m <= 2^(WIDTH-1), so only the shifted value needs the extra bit
  assign r_shift = {r_q, (cnt_q == {k_q, 1'b0})};
  assign r_ge    = (r_shift >= {1'b0, m_q});
  assign r_next  = r_ge ? WIDTH'(r_shift - {1'b0, m_q}) : WIDTH'(r_shift);
  assign q_next  = WIDTH'({q_q, r_ge});

`ifdef BARRETT_PRECOMP_CACHE_EN
  logic             cache_valid_q;
  logic [WIDTH-1:0] cache_m_q, cache_mu_q;
  logic [KW-1:0]    cache_k_q;

  assign cache_hit = cache_valid_q && (cache_m_q == m_q);
  assign hit_k     = cache_k_q;
  assign hit_mu    = cache_mu_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cache_valid_q <= 1'b0;
      cache_m_q     <= '0;
      cache_k_q     <= '0;
      cache_mu_q    <= '0;
    end else if ((state_q == DIV) && div_last) begin
      cache_valid_q <= 1'b1;
      cache_m_q     <= m_q;
      cache_k_q     <= k_q;
      cache_mu_q    <= q_next;
    end
  end
`else
  assign cache_hit = 1'b0;
  assign hit_k     = '0;
  assign hit_mu    = '0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = LEN;
      LEN:     state_d = (len_err || cache_hit) ? DONE : DIV;
      DIV:     if (div_last) state_d = DONE;
      DONE:    state_d = start_i ? LEN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Results are registered on the edge entering DONE and held until the next DONE
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_o  <= 1'b0;
      valid_o <= 1'b0;
      error_o <= 1'b0;
      m_o     <= '0;
      m_bl_o  <= '0;
      mu_o    <= '0;
      m_q     <= '0;
      q_q     <= '0;
      r_q     <= '0;
      k_q     <= '0;
      cnt_q   <= '0;
    end else begin
      busy_o  <= (state_d == LEN) || (state_d == DIV);
      valid_o <= (state_d == DONE);
      if (accept) m_q <= m_i;
      case (state_q)
        LEN: begin
          k_q   <= len_k;
          r_q   <= '0;
          q_q   <= '0;
          cnt_q <= {len_k, 1'b0};
          if (len_err) begin
            error_o <= 1'b1;
            m_o     <= m_q;
            m_bl_o  <= '0;
            mu_o    <= '0;
          end else if (cache_hit) begin
            error_o <= 1'b0;
            m_o     <= m_q;
            m_bl_o  <= WIDTH'(hit_k);
            mu_o    <= hit_mu;
          end
        end
        DIV: begin
          r_q   <= r_next;
          q_q   <= q_next;
          cnt_q <= cnt_q - CW'(1);
          if (div_last) begin
            error_o <= 1'b0;
            m_o     <= m_q;
            m_bl_o  <= WIDTH'(k_q);
            mu_o    <= q_next;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_barrett_precompute.sv
// Testbench for barrett_precompute: vector table plus corner sequences, with results
// checked against a scoreboard queue whenever valid_o pulses.
module tb_barrett_precompute;
  localparam int WIDTH = 64;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             start = 1'b0;
  logic [WIDTH-1:0] m_in = '0;
  logic             busy, valid, err;
  logic [WIDTH-1:0] m_out, m_bl, mu;

  typedef struct {
    logic [63:0] m;
    logic [63:0] bl;
    logic [63:0] mu;
    logic        err;
    int          lat;
    string       name;
  } vec_t;

  typedef struct {
    vec_t v;
    int   acc;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[10];
  int   edge_cnt = 0;
  int   passed = 0;
  int   total = 0;
  int   cache_lat;

  barrett_precompute #(.WIDTH(WIDTH)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .start_i (start),
    .m_i     (m_in),
    .busy_o  (busy),
    .valid_o (valid),
    .error_o (err),
    .m_o     (m_out),
    .m_bl_o  (m_bl),
    .mu_o    (mu)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Every valid_o pulse must match the oldest outstanding request
  always @(negedge clk) begin
    if (rst_n && valid) begin
      if (sb.size() == 0) begin
        check_output("spurious_valid", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_output({e.v.name, "_m"},    m_out, e.v.m);
        check_output({e.v.name, "_bl"},   m_bl,  e.v.bl);
        check_output({e.v.name, "_mu"},   mu,    e.v.mu);
        check_output({e.v.name, "_err"},  64'(err),  64'(e.v.err));
        check_output({e.v.name, "_busy"}, 64'(busy), 64'd0);
        check_output({e.v.name, "_lat"},  64'(edge_cnt - e.acc + 1), 64'(e.v.lat));
      end
    end
  end

  task automatic push_exp(input vec_t v, input int acc);
    exp_t e;
    e.v   = v;
    e.acc = acc;
    sb.push_back(e);
  endtask

  task automatic apply_stimulus(input vec_t v);
    @(negedge clk);
    start = 1'b1;
    m_in  = v.m;
    push_exp(v, edge_cnt + 1);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain(input int bound);
    int n = 0;
    while (sb.size() != 0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      check_output("timeout", 64'(sb.size()), 64'd0);
      sb.delete();
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    start = 1'b0;
    #1;
    check_output("rst_busy",  64'(busy),  64'd0);
    check_output("rst_valid", 64'(valid), 64'd0);
    check_output("rst_err",   64'(err),   64'd0);
    check_output("rst_m",     m_out, 64'd0);
    check_output("rst_bl",    m_bl,  64'd0);
    check_output("rst_mu",    mu,    64'd0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic vec_t mk(input logic [63:0] m, input logic [63:0] bl, input logic [63:0] mu_v,
                              input logic e, input int lat, input string name);
    vec_t v;
    v.m = m; v.bl = bl; v.mu = mu_v; v.err = e; v.lat = lat; v.name = name;
    return v;
  endfunction

  initial begin
    int acc;
    tbl[0] = mk(64'hD01,               64'hC,  64'h13AF,               1'b0, 27,  "m_d01");
    tbl[1] = mk(64'h7FE001,            64'h17, 64'h802007,             1'b0, 49,  "m_7fe001");
    tbl[2] = mk(64'h7FFFFFFF,          64'h1F, 64'h80000001,           1'b0, 65,  "m_7fffffff");
    tbl[3] = mk(64'h1000,              64'hC,  64'h1000,               1'b0, 27,  "m_1000");
    tbl[4] = mk(64'h1,                 64'h0,  64'h1,                  1'b0, 3,   "m_1");
    tbl[5] = mk(64'h0,                 64'h0,  64'h0,                  1'b1, 2,   "m_0");
    tbl[6] = mk(64'h8000000000000001,  64'h0,  64'h0,                  1'b1, 2,   "m_too_big");
    tbl[7] = mk(64'h8000000000000000,  64'h3F, 64'h8000000000000000,   1'b0, 129, "m_2p63");
    tbl[8] = mk(64'h3,                 64'h2,  64'h5,                  1'b0, 7,   "m_3");
    tbl[9] = mk(64'h2,                 64'h1,  64'h2,                  1'b0, 5,   "m_2");

    do_reset();

    for (int i = 0; i < 10; i++) begin
      apply_stimulus(tbl[i]);
      drain(300);
    end

    // start pulsed mid-division with another modulus must not disturb the result
    do_reset();
    apply_stimulus(tbl[1]);
    repeat (10) @(negedge clk);
    check_output("busy_mid_div", 64'(busy), 64'd1);
    start = 1'b1;
    m_in  = 64'h1000;
    @(negedge clk);
    start = 1'b0;
    drain(300);

    // reset mid-division clears outputs; next request runs in full
    apply_stimulus(tbl[0]);
    repeat (10) @(negedge clk);
    do_reset();
    apply_stimulus(tbl[0]);
    drain(300);

    // back-to-back: start held high through the first run, new modulus taken in DONE
    do_reset();
    @(negedge clk);
    start = 1'b1;
    m_in  = tbl[0].m;
    acc   = edge_cnt + 1;
    push_exp(tbl[0], acc);
    push_exp(tbl[1], acc + 27);
    @(negedge clk);
    m_in = tbl[1].m;
    repeat (27) @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    drain(300);

    // repeated modulus: cache hit when configured, full division otherwise
`ifdef BARRETT_PRECOMP_CACHE_EN
    cache_lat = 2;
`else
    cache_lat = 27;
`endif
    do_reset();
    apply_stimulus(tbl[0]);
    drain(300);
    apply_stimulus(mk(64'hD01, 64'hC, 64'h13AF, 1'b0, cache_lat, "m_d01_repeat"));
    drain(300);
    do_reset();
    apply_stimulus(mk(64'hD01, 64'hC, 64'h13AF, 1'b0, 27, "m_d01_after_rst"));
    drain(300);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
